sync_fifo_param: RTL and testbench
==================================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; power of two, >= 2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, count at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 2, count at or below which almost_empty asserts.
REQ-005 SHALL derive local AW = log2(DEPTH); the count width is AW+1.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port wr, input, 1, write request.
REQ-009 SHALL have port rd, input, 1, read request.
REQ-010 SHALL have port din, input, DWIDTH, write data.
REQ-011 SHALL have port dout, output, DWIDTH, registered read data.
REQ-012 SHALL have port wrptr, output, AW, write address.
REQ-013 SHALL have port rdptr, output, AW, read address.
REQ-014 SHALL have port count, output, AW+1, occupancy.
REQ-015 SHALL have port full, output, 1, asserted while count == DEPTH.
REQ-016 SHALL have port empty, output, 1, asserted while count == 0.
REQ-017 SHALL have port almost_full, output, 1, asserted while count >= AF_LEVEL.
REQ-018 SHALL have port almost_empty, output, 1, asserted while count <= AE_LEVEL.
REQ-019 SHALL have port overflow, output, 1, sticky write-while-full error.
REQ-020 SHALL have port underflow, output, 1, sticky read-while-empty error.

Function
REQ-021 SHALL accept a read when rd && !empty; dout SHALL take mem[rdptr] on that edge (1-cycle latency), and rdptr SHALL increment.
REQ-022 SHALL accept a write when wr && (!full || read accepted in the same cycle); mem[wrptr] SHALL take din on that edge, and wrptr SHALL increment.
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0 with no extra cycle.
REQ-024 Count SHALL change as follows: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-025 When empty and both wr and rd are high, the write SHALL be accepted, the read SHALL be ignored (no bypass), dout SHALL hold, and underflow SHALL set.
REQ-026 When full and both wr and rd are high, both SHALL be accepted and count SHALL stay DEPTH.
REQ-027 dout SHALL hold its last value in every cycle without an accepted read.
REQ-028 SHALL implement a state register with states EMPTY(0), PARTIAL(1), FULL(2), updated each edge from the next count:
- 0 -> EMPTY
- DEPTH -> FULL
- otherwise -> PARTIAL
REQ-029 full and empty SHALL be decoded from the state register.
REQ-030 All status outputs SHALL be registered and consistent with count in the same cycle.

Reset
REQ-031 On rst high at a clock edge, the following SHALL clear: wrptr, rdptr, count and dout to 0; state to EMPTY; empty and almost_empty to 1; full, almost_full, overflow and underflow to 0.
REQ-032 rst SHALL take priority over a simultaneous wr or rd; memory contents need not clear.
REQ-033 A reset mid-operation SHALL discard all stored words; the first read after reset SHALL return the first word written after reset.

Configuration
REQ-034 With macro FIFO_ERR_FLAGS_EN defined:
- overflow SHALL set on wr && !write-accepted.
- underflow SHALL set on rd && empty.
- Both SHALL stay set until rst.
REQ-035 Without FIFO_ERR_FLAGS_EN, overflow and underflow SHALL be constant 0 and their logic SHALL not be synthesised.

Structure
REQ-036 Package fifo_pkg SHALL hold typedef fifo_state_t {EMPTY=0, PARTIAL=1, FULL=2} and a clog2-based width function.
REQ-037 Storage SHALL be sub-module fifo_mem: one write port and one registered read port, parameters DWIDTH and DEPTH.
REQ-038 The state register SHALL be hierarchically visible as "state" for bench decoding.

Verification
REQ-039 Fill: reset, then write DEPTH=16 words 0x01..0x10 -> after the 16th write full=1, count=16, state=FULL, almost_full asserted from count 14.
REQ-040 Overflow: write a 17th word 0xAA when full -> the write is dropped, overflow=1 (FIFO_ERR_FLAGS_EN), and a drain then returns 0x01..0x10 in order.
REQ-041 Underflow: assert rd when empty -> dout is unchanged, count stays 0, underflow=1; with the macro undefined, underflow=0.
REQ-042 Simultaneous operations: hold wr=rd=1 for 40 cycles at count 5 -> count stays 5, both pointers wrap past 15, and data order is preserved.
REQ-043 Full and empty edge cases:
- wr=rd=1 when full -> count stays 16, dout = oldest word.
- wr=rd=1 when empty -> count becomes 1, dout is unchanged.
REQ-044 Mid-operation reset: write 3 words, assert rst for 1 cycle, write 0x5A, then read -> dout=0x5A and empty=1 afterwards.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO.
package fifo_pkg;

    // Occupancy class held in the FIFO state register
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fifo_state_t;

    // Address width for a given depth; never narrower than one bit
    function automatic int fifo_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one write port, one registered read port.
// The read register holds its value unless a read is enabled.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = fifo_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [DWIDTH-1:0] r_rdata;

    // Array write; contents are not cleared by reset
    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
    end

    // Registered read data, cleared on reset, held when no read
    always_ff @(posedge clk) begin
        if (rst)     r_rdata <= '0;
        else if (re) r_rdata <= r_mem[raddr];
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parameterised FIFO with registered status flags.
// Optional sticky overflow/underflow flags: define FIFO_ERR_FLAGS_EN.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DWIDTH   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int AW      = fifo_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout,
    output logic [AW-1:0]     wrptr,
    output logic [AW-1:0]     rdptr,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_CNT    = (AW+1)'(AE_LEVEL);

    fifo_state_t   state, w_state_nxt;
    logic [AW-1:0] r_wrptr, r_rdptr;
    logic [AW:0]   r_count, w_count_nxt;
    logic          r_af, r_ae;
    logic          w_rd_acc, w_wr_acc;

    // A read needs data; a write needs room, or a slot freed by a same-cycle read
    assign w_rd_acc = rd && (state != EMPTY);
    assign w_wr_acc = wr && ((state != FULL) || w_rd_acc);

    // Occupancy after this edge
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc)      w_count_nxt = r_count + 1'b1;
        else if (!w_wr_acc && w_rd_acc) w_count_nxt = r_count - 1'b1;
    end

    // Next state classified from next occupancy
    always_comb begin
        w_state_nxt = PARTIAL;
        if (w_count_nxt == '0)             w_state_nxt = EMPTY;
        else if (w_count_nxt == DEPTH_CNT) w_state_nxt = FULL;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= w_state_nxt;
    end

    // Pointers, count and threshold flags; power-of-two depth wraps for free
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrptr <= '0;
            r_rdptr <= '0;
            r_count <= '0;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
        end else begin
            if (w_wr_acc) r_wrptr <= r_wrptr + 1'b1;
            if (w_rd_acc) r_rdptr <= r_rdptr + 1'b1;
            r_count <= w_count_nxt;
            r_af    <= (w_count_nxt >= AF_CNT);
            r_ae    <= (w_count_nxt <= AE_CNT);
        end
    end

    fifo_mem #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (w_wr_acc),
        .waddr (r_wrptr),
        .wdata (din),
        .re    (w_rd_acc),
        .raddr (r_rdptr),
        .rdata (dout)
    );

    assign wrptr        = r_wrptr;
    assign rdptr        = r_rdptr;
    assign count        = r_count;
    assign full         = (state == FULL);
    assign empty        = (state == EMPTY);
    assign almost_full  = r_af;
    assign almost_empty = r_ae;

`ifdef FIFO_ERR_FLAGS_EN
    logic r_ovf, r_unf;

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (wr && !w_wr_acc)       r_ovf <= 1'b1;
            if (rd && (state == EMPTY)) r_unf <= 1'b1;
        end
    end

    assign overflow  = r_ovf;
    assign underflow = r_unf;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DWIDTH=8, DEPTH=16 defaults).
module tb_sync_fifo_param;

`ifdef FIFO_ERR_FLAGS_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, wr, rd;
    logic [7:0] din, dout;
    logic [3:0] wrptr, rdptr;
    logic [4:0] count;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;

    int errors = 0;
    int checks = 0;

    sync_fifo_param dut (
        .clk          (clk),
        .rst          (rst),
        .wr           (wr),
        .rd           (rd),
        .din          (din),
        .dout         (dout),
        .wrptr        (wrptr),
        .rdptr        (rdptr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr, rd;
        logic [7:0] din, dout;
        logic [4:0] cnt;
        logic       ful, emp, af, ae;
        logic [1:0] st;
        logic       ovf, unf;
    } vec_t;

    vec_t tbl [34];

    function automatic vec_t mk(input logic w, input logic r, input logic [7:0] d,
                                input logic [7:0] q, input int c, input logic [1:0] s,
                                input logic ov, input logic un);
        vec_t v;
        v.wr = w; v.rd = r; v.din = d; v.dout = q; v.cnt = 5'(c);
        v.ful = (c == 16); v.emp = (c == 0); v.af = (c >= 14); v.ae = (c <= 2);
        v.st = s; v.ovf = ov; v.unf = un;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle, then sample 1 time unit after the edge
    task automatic tick(input logic w, input logic r, input logic [7:0] d);
        wr = w; rd = r; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
    endtask

    task automatic chk_st(input string nm, input int c, input logic [1:0] s);
        logic [1:0] st;
        st = dut.state;
        chk({nm, ".count"}, 32'(count), 32'(c));
        chk({nm, ".full"},  32'(full),  32'(c == 16));
        chk({nm, ".empty"}, 32'(empty), 32'(c == 0));
        chk({nm, ".state"}, 32'(st),    32'(s));
    endtask

    initial begin
        logic [1:0] st;
        int n;
        rst = 1'b1; wr = 1'b0; rd = 1'b0; din = 8'h00;

        // Table: fill, overflow attempt, drain, underflow attempt
        n = 0;
        for (int i = 1; i <= 16; i++)
            tbl[n++] = mk(1, 0, 8'(i), 8'h00, i, (i == 16) ? 2'd2 : 2'd1, 0, 0);
        tbl[n++] = mk(1, 0, 8'hAA, 8'h00, 16, 2'd2, ERR, 0);
        for (int i = 1; i <= 16; i++)
            tbl[n++] = mk(0, 1, 8'h00, 8'(i), 16 - i, (i == 16) ? 2'd0 : 2'd1, ERR, 0);
        tbl[n++] = mk(0, 1, 8'h00, 8'h10, 0, 2'd0, ERR, ERR);

        // Reset state
        tick(1'b1, 1'b1, 8'hFF);
        do_reset();
        st = dut.state;
        chk("rst.count", 32'(count), 0);
        chk("rst.empty", 32'(empty), 1);
        chk("rst.full", 32'(full), 0);
        chk("rst.ae", 32'(almost_empty), 1);
        chk("rst.af", 32'(almost_full), 0);
        chk("rst.ovf", 32'(overflow), 0);
        chk("rst.unf", 32'(underflow), 0);
        chk("rst.dout", 32'(dout), 0);
        chk("rst.wrptr", 32'(wrptr), 0);
        chk("rst.rdptr", 32'(rdptr), 0);
        chk("rst.state", 32'(st), 0);

        for (int i = 0; i < 34; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            tick(tbl[i].wr, tbl[i].rd, tbl[i].din);
            st = dut.state;
            chk({nm, ".dout"},  32'(dout),         32'(tbl[i].dout));
            chk({nm, ".count"}, 32'(count),        32'(tbl[i].cnt));
            chk({nm, ".full"},  32'(full),         32'(tbl[i].ful));
            chk({nm, ".empty"}, 32'(empty),        32'(tbl[i].emp));
            chk({nm, ".af"},    32'(almost_full),  32'(tbl[i].af));
            chk({nm, ".ae"},    32'(almost_empty), 32'(tbl[i].ae));
            chk({nm, ".state"}, 32'(st),           32'(tbl[i].st));
            chk({nm, ".ovf"},   32'(overflow),     32'(tbl[i].ovf));
            chk({nm, ".unf"},   32'(underflow),    32'(tbl[i].unf));
            if (i == 16) begin
                chk("ovf.wrptr", 32'(wrptr), 0);
                chk("ovf.rdptr", 32'(rdptr), 0);
            end
        end

        // Simultaneous wr/rd at count 5 for 40 cycles; pointers wrap
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 8'h20 + 8'(i));
        chk_st("sim.pre", 5, 2'd1);
        for (int k = 0; k < 40; k++) begin
            tick(1'b1, 1'b1, 8'h25 + 8'(k));
            chk($sformatf("sim%0d.dout", k), 32'(dout), 32'(8'h20 + 8'(k)));
            chk($sformatf("sim%0d.count", k), 32'(count), 5);
        end
        chk("sim.wrptr", 32'(wrptr), 13);
        chk("sim.rdptr", 32'(rdptr), 8);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1, 8'h00);
            chk($sformatf("simdrain%0d.dout", i), 32'(dout), 32'(8'h48 + 8'(i)));
        end
        chk_st("sim.post", 0, 2'd0);
        chk("sim.ovf", 32'(overflow), 0);
        chk("sim.unf", 32'(underflow), 0);

        // wr=rd=1 while full: both accepted, oldest word out
        do_reset();
        for (int i = 0; i < 16; i++) tick(1'b1, 1'b0, 8'h30 + 8'(i));
        chk_st("full.pre", 16, 2'd2);
        tick(1'b1, 1'b1, 8'h77);
        chk_st("fullrw", 16, 2'd2);
        chk("fullrw.dout", 32'(dout), 32'h30);
        chk("fullrw.ovf", 32'(overflow), 0);
        chk("fullrw.wrptr", 32'(wrptr), 1);
        chk("fullrw.rdptr", 32'(rdptr), 1);

        // wr=rd=1 while empty: write only, dout holds
        do_reset();
        tick(1'b1, 1'b0, 8'h11);
        tick(1'b0, 1'b1, 8'h00);
        chk("emp.pre.dout", 32'(dout), 32'h11);
        tick(1'b1, 1'b1, 8'h66);
        chk_st("emprw", 1, 2'd1);
        chk("emprw.dout", 32'(dout), 32'h11);
        chk("emprw.unf", 32'(underflow), 32'(ERR));
        tick(1'b0, 1'b1, 8'h00);
        chk("emprw.read", 32'(dout), 32'h66);
        chk_st("emprw.post", 0, 2'd0);

        // Reset mid-operation discards contents and wins over wr
        do_reset();
        for (int i = 1; i <= 3; i++) tick(1'b1, 1'b0, 8'(i));
        tick(1'b0, 1'b1, 8'h00);
        chk("mid.pre.dout", 32'(dout), 1);
        rst = 1'b1;
        tick(1'b1, 1'b0, 8'h99);
        rst = 1'b0;
        chk_st("mid.rst", 0, 2'd0);
        chk("mid.rst.dout", 32'(dout), 0);
        chk("mid.rst.wrptr", 32'(wrptr), 0);
        chk("mid.rst.unf", 32'(underflow), 0);
        tick(1'b1, 1'b0, 8'h5A);
        chk_st("mid.wr", 1, 2'd1);
        tick(1'b0, 1'b1, 8'h00);
        chk("mid.rd.dout", 32'(dout), 32'h5A);
        chk_st("mid.rd", 0, 2'd0);
        tick(1'b0, 1'b0, 8'h00);
        chk("mid.hold.dout", 32'(dout), 32'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
